// File: rtl/rr_arb_4.sv
// Four-way round-robin arbiter with a bounded hold time per owner.
// All outputs are registered; the grant steers a shared 4:1 mux through SEL/VALID.
module rr_arb_4 #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    output logic [3:0] GNT,
    output logic [1:0] SEL,
    output logic       VALID
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    state_t     state_q;
    logic [1:0] ptr_q;
    logic [1:0] owner_q;
    logic [7:0] hcnt_q;
    logic [3:0] gnt_q;
    logic [1:0] sel_q;
    logic       valid_q;

    logic [3:0] owner_mask;
    logic [3:0] others;
    logic [3:0] cand;
    logic       cand_any;
    logic       at_limit;
    logic       keep;
    logic       found;
    logic [1:0] idx;
    logic [1:0] winner;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        owner_mask = 4'b0001 << owner_q;
        others     = REQ & ~owner_mask;
        at_limit   = (hcnt_q >= HOLD_MAX);
        keep       = (state_q == BUSY) && ((REQ & owner_mask) != 4'b0000)
                     && (!at_limit || (others == 4'b0000));
        // While busy the owner is masked so a forced release picks someone else.
        cand       = (state_q == BUSY) ? others : REQ;
        cand_any   = |cand;
        found      = 1'b0;
        idx        = ptr_q;
        winner     = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && cand[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // NOTE: state and registered outputs use non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
            hcnt_q  <= 8'd0;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            valid_q <= 1'b0;
        end else if (keep) begin
            hcnt_q <= at_limit ? 8'd1 : hcnt_q + 8'd1;
        end else if (cand_any) begin
            state_q <= BUSY;
            owner_q <= winner;
            gnt_q   <= 4'b0001 << winner;
            sel_q   <= winner;
            valid_q <= 1'b1;
            hcnt_q  <= 8'd1;
            ptr_q   <= winner + 2'd1;
        end else begin
            // No requester at all: drop the grant but leave SEL on the last owner.
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
        end
    end

    assign GNT   = gnt_q;
    assign SEL   = sel_q;
    assign VALID = valid_q;

endmodule

// File: tb/tb_rr_arb_4.sv
// Bench for rr_arb_4: directed scenarios plus random traffic against a rule-level model.
// Two instances: MAX_HOLD=4 and MAX_HOLD=1.
module tb_rr_arb_4;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] req0, req1;
    logic [3:0] gnt0, gnt1;
    logic [1:0] sel0, sel1;
    logic       valid0, valid1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    rr_arb_4 #(.MAX_HOLD(4)) dut (
        .CLK(CLK), .RST(RST), .REQ(req0), .GNT(gnt0), .SEL(sel0), .VALID(valid0)
    );

    rr_arb_4 #(.MAX_HOLD(1)) dut1 (
        .CLK(CLK), .RST(RST), .REQ(req1), .GNT(gnt1), .SEL(sel1), .VALID(valid1)
    );

    // Reference model: who owns the bus, for how long, and where the next scan starts.
    int m_busy[2], m_owner[2], m_ptr[2], m_hcnt[2], m_sel[2];

    function automatic int pick(input logic [3:0] mask, input int ptr);
        for (int k = 0; k < 4; k++)
            if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    task automatic model_step(input int i, input int mh, input logic [3:0] req);
        logic [3:0] others;
        int w;
        w = -1;
        if (m_busy[i] != 0) begin
            others = req & ~(4'b0001 << m_owner[i]);
            if (req[m_owner[i]] && m_hcnt[i] < mh) m_hcnt[i] = m_hcnt[i] + 1;
            else if (req[m_owner[i]] && others == 4'b0000) m_hcnt[i] = 1;
            else begin
                w = pick(others, m_ptr[i]);
                if (w < 0) m_busy[i] = 0;
            end
        end else begin
            w = pick(req, m_ptr[i]);
        end
        if (w >= 0) begin
            m_busy[i]  = 1;
            m_owner[i] = w;
            m_sel[i]   = w;
            m_hcnt[i]  = 1;
            m_ptr[i]   = (w + 1) % 4;
        end
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 0; m_owner[i] = 0; m_ptr[i] = 0; m_hcnt[i] = 0; m_sel[i] = 0;
            end
        end else begin
            model_step(0, 4, req0);
            model_step(1, 1, req1);
        end
    end

    task automatic do_reset();
        RST  = 1'b1;
        req0 = 4'b0000;
        req1 = 4'b0000;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST  = 1'b1;
        req0 = 4'b1111;
        req1 = 4'b1111;
        repeat (3) @(negedge CLK);
        n_tests++;
        if (gnt0 !== 4'b0000 || sel0 !== 2'd0 || valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: gnt=%b sel=%0d valid=%b, expected 0000/0/0", gnt0, sel0, valid0);
        end
        n_tests++;
        if (gnt1 !== 4'b0000 || valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ignores_req: gnt=%b valid=%b, expected 0000/0", gnt1, valid1);
        end
        RST  = 1'b0;
        req0 = 4'b0000;
        req1 = 4'b0000;
    endtask

    task automatic test_single_hold();
        do_reset();
        req0 = 4'b0100;
        #1;
        n_tests++;
        if (gnt0 !== 4'b0000) begin
            n_fail++;
            $display("FAIL no_comb_path: gnt=%b before edge, expected 0000", gnt0);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            n_tests++;
            if (gnt0 !== 4'b0100 || sel0 !== 2'd2 || valid0 !== 1'b1) begin
                n_fail++;
                $display("FAIL single_hold[%0d]: gnt=%b sel=%0d valid=%b, expected 0100/2/1",
                         c, gnt0, sel0, valid0);
            end
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g;
        int exp_o;
        do_reset();
        req0 = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            exp_o = (c / 4) % 4;
            exp_g = 4'b0001 << exp_o;
            n_tests++;
            if (gnt0 !== exp_g || sel0 !== 2'(exp_o) || valid0 !== 1'b1) begin
                n_fail++;
                $display("FAIL rotation[%0d]: gnt=%b sel=%0d valid=%b, expected %b/%0d/1",
                         c, gnt0, sel0, valid0, exp_g, exp_o);
            end
        end
    endtask

    task automatic test_handover();
        do_reset();
        req0 = 4'b0010;
        @(negedge CLK);
        n_tests++;
        if (gnt0 !== 4'b0010) begin
            n_fail++;
            $display("FAIL handover_setup: gnt=%b, expected 0010", gnt0);
        end
        req0 = 4'b1001;
        @(negedge CLK);
        n_tests++;
        if (gnt0 !== 4'b1000 || sel0 !== 2'd3 || valid0 !== 1'b1) begin
            n_fail++;
            $display("FAIL handover: gnt=%b sel=%0d valid=%b, expected 1000/3/1", gnt0, sel0, valid0);
        end
    endtask

    task automatic test_idle_return();
        do_reset();
        req0 = 4'b0100;
        @(negedge CLK);
        req0 = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            n_tests++;
            if (gnt0 !== 4'b0000 || valid0 !== 1'b0 || sel0 !== 2'd2) begin
                n_fail++;
                $display("FAIL idle_return[%0d]: gnt=%b sel=%0d valid=%b, expected 0000/2/0",
                         c, gnt0, sel0, valid0);
            end
        end
        req0 = 4'b0001;
        @(negedge CLK);
        n_tests++;
        if (gnt0 !== 4'b0001 || sel0 !== 2'd0 || valid0 !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_regrant: gnt=%b sel=%0d valid=%b, expected 0001/0/1", gnt0, sel0, valid0);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req0 = 4'b0010;
        @(negedge CLK);
        n_tests++;
        if (gnt0 !== 4'b0010) begin
            n_fail++;
            $display("FAIL async_setup: gnt=%b, expected 0010", gnt0);
        end
        #2 RST = 1'b1;
        #1;
        n_tests++;
        if (gnt0 !== 4'b0000 || sel0 !== 2'd0 || valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: gnt=%b sel=%0d valid=%b, expected 0000/0/0", gnt0, sel0, valid0);
        end
        @(negedge CLK);
        RST  = 1'b0;
        req0 = 4'b1010;
        @(negedge CLK);
        n_tests++;
        if (gnt0 !== 4'b0010 || sel0 !== 2'd1 || valid0 !== 1'b1) begin
            n_fail++;
            $display("FAIL async_first_grant: gnt=%b sel=%0d, expected 0010/1", gnt0, sel0);
        end
    endtask

    task automatic test_max_hold_one();
        logic [3:0] exp_g;
        do_reset();
        req1 = 4'b0011;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            exp_g = (c % 2 == 0) ? 4'b0001 : 4'b0010;
            n_tests++;
            if (gnt1 !== exp_g || valid1 !== 1'b1) begin
                n_fail++;
                $display("FAIL max_hold_one[%0d]: gnt=%b valid=%b, expected %b/1", c, gnt1, valid1, exp_g);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_g0, exp_g1;
        do_reset();
        req0 = 4'($urandom_range(0, 15));
        req1 = 4'($urandom_range(0, 15));
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            exp_g0 = (m_busy[0] != 0) ? (4'b0001 << m_owner[0]) : 4'b0000;
            exp_g1 = (m_busy[1] != 0) ? (4'b0001 << m_owner[1]) : 4'b0000;
            n_tests++;
            if (gnt0 !== exp_g0 || sel0 !== 2'(m_sel[0]) || valid0 !== (m_busy[0] != 0)) begin
                n_fail++;
                $display("FAIL random_mh4[%0d]: gnt=%b sel=%0d valid=%b, expected %b/%0d/%0d",
                         c, gnt0, sel0, valid0, exp_g0, m_sel[0], m_busy[0]);
            end
            n_tests++;
            if (gnt1 !== exp_g1 || sel1 !== 2'(m_sel[1]) || valid1 !== (m_busy[1] != 0)) begin
                n_fail++;
                $display("FAIL random_mh1[%0d]: gnt=%b sel=%0d valid=%b, expected %b/%0d/%0d",
                         c, gnt1, sel1, valid1, exp_g1, m_sel[1], m_busy[1]);
            end
            if ($urandom_range(0, 3) == 0) req0 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req1 = 4'($urandom_range(0, 15));
        end
    endtask

    initial begin
        test_reset();
        test_single_hold();
        test_rotation();
        test_handover();
        test_idle_return();
        test_async_reset();
        test_max_hold_one();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rr_arb_4.md
RR_ARB_4 -- requirements
Module: rr_arb_4

Interface
REQ-001 Parameter: MAX_HOLD, 4, maximum consecutive grant cycles per owner while another requester waits (legal 1..255).
REQ-002 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Port: RST  input  1  reset; asynchronous, active-high.
REQ-004 Port: REQ  input  4  request per requester; bit i = requester i.
REQ-005 Port: GNT  output  4  grant; one-hot or zero.
REQ-006 Port: SEL  output  2  index of current or last owner; drives SEL of the shared mux_4.
REQ-007 Port: VALID  output  1  high when GNT is non-zero; qualifies the mux output.

Function
REQ-008 GNT, SEL and VALID shall be registered outputs; no combinational path from REQ to any output.
REQ-009 Two states shall exist: IDLE (no owner) and BUSY (one owner).
REQ-010 Internal state shall be a 2-bit priority pointer PTR, a 2-bit OWNER and an 8-bit hold counter HCNT.
REQ-011 Winner selection: the first asserted REQ bit scanning PTR, PTR+1, PTR+2, PTR+3 (mod 4).
REQ-012 IDLE with REQ != 0: next edge enters BUSY; GNT = one-hot(winner); SEL = winner; VALID = 1; HCNT = 1; PTR = winner+1 mod 4 (3 wraps to 0); latency is exactly 1 cycle.
REQ-013 IDLE with REQ == 0: remain in IDLE; GNT = 0; VALID = 0; SEL holds its last value.
REQ-014 BUSY, REQ[OWNER] = 1, HCNT < MAX_HOLD: keep owner; HCNT increments by 1.
REQ-015 BUSY, REQ[OWNER] = 0: release; if any other REQ bit is set, grant the winner per REQ-011 on the same edge (no idle cycle), HCNT = 1; otherwise go to IDLE with GNT = 0 and VALID = 0.
REQ-016 BUSY, REQ[OWNER] = 1, HCNT == MAX_HOLD, another REQ bit set: forced release; the winner is selected with REQ[OWNER] masked; handover per REQ-015.
REQ-017 BUSY, REQ[OWNER] = 1, HCNT == MAX_HOLD, no other REQ: keep owner; HCNT reloads to 1 (HCNT never wraps past MAX_HOLD).
REQ-018 MAX_HOLD = 1: a contended owner shall rotate every cycle.
REQ-019 GNT and SEL shall change only at an owner change; SEL shall equal OWNER whenever VALID = 1.
REQ-020 A requester that is already owner and is re-selected at a handover (REQ-015 with no other requests) does not occur; the pointer guarantees every continuously requesting requester is granted within 3*MAX_HOLD+3 cycles.

Reset
REQ-021 RST = 1 shall immediately (asynchronously) force IDLE: GNT = 0, SEL = 0, VALID = 0, PTR = 0, OWNER = 0, HCNT = 0.
REQ-022 Reset asserted mid-grant shall drop GNT without waiting for a clock edge; after reset deassertion the first grant follows REQ-012 from PTR = 0.
REQ-023 While RST = 1, REQ shall be ignored.

Verification
REQ-024 Reset, then REQ=4'b0100 held -> one edge later GNT=4'b0100, SEL=2, VALID=1; GNT holds indefinitely (REQ-017).
REQ-025 MAX_HOLD=4, REQ=4'b1111 held from reset -> owners 0,1,2,3,0 in 4-cycle blocks with no gap cycles; SEL 0,1,2,3,0.
REQ-026 Owner 1 drops REQ while REQ=4'b1001 -> next edge GNT=4'b1000 (PTR=2 scan reaches 3 first), SEL=3, VALID stays 1.
REQ-027 Sole owner 2 drops REQ, REQ=0 -> next edge GNT=0, VALID=0, SEL stays 2; then REQ=4'b0001 -> GNT=4'b0001 one edge later.
REQ-028 RST pulsed mid-cycle while GNT=4'b0010 -> GNT=0, SEL=0, VALID=0 before the next CLK edge; after release with REQ=4'b1010, first GNT=4'b0010.
REQ-029 MAX_HOLD=1, REQ=4'b0011 held -> GNT alternates 4'b0001, 4'b0010 every cycle.
